rx_d2c_sweep_test_ctrl: RTL and testbench

RX_D2C_SWEEP_TEST_CTRL -- requirements
Module: rx_d2c_sweep_test_ctrl

---
 rtl/rx_d2c_pt_pkg.sv | 42 ++++
 rtl/sb_msg_sender.sv | 54 +++++
 rtl/rx_d2c_sweep_test_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_rx_d2c_sweep_test_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_d2c_pt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_d2c_pt_pkg
//  Description : Shared definitions for the RX data-to-clock point-test
//                sweep controller: sideband message codes, mainband pattern
//                comparator control words, FSM state encoding and the
//                point-index to clock-phase mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_d2c_pt_pkg;

   // Sideband message codes exchanged with the link partner
   localparam logic [3:0] START_REQ  = 4'd1;
   localparam logic [3:0] START_RESP = 4'd2;
   localparam logic [3:0] END_REQ    = 4'd3;
   localparam logic [3:0] END_RESP   = 4'd4;

   // Mainband pattern comparator control words
   localparam logic [1:0] CW_IDLE        = 2'b00;
   localparam logic [1:0] CW_CLEAR_LFSR  = 2'b01;
   localparam logic [1:0] CW_LFSR        = 2'b10;

   typedef enum logic [3:0] {
      ST_IDLE            = 4'd0,
      ST_SEND_START      = 4'd1,
      ST_WAIT_START_RESP = 4'd2,
      ST_CLR_LFSR        = 4'd3,
      ST_RUN             = 4'd4,
      ST_SEND_END        = 4'd5,
      ST_WAIT_END_RESP   = 4'd6,
      ST_NEXT            = 4'd7,
      ST_DONE            = 4'd8,
      ST_ERROR           = 4'd9
   } state_t;

   // Clock phase rotates center (0), left (1), right (2) across points
   function automatic logic [1:0] clk_phase(input logic [3:0] idx);
      return 2'(idx % 4'd3);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sb_msg_sender.sv
`default_nettype none
// ============================================================================
//  Module      : sb_msg_sender
//  Description : Sideband send handshake. While 'send' is high the message
//                code, data-valid flag and data word are presented with the
//                message request held high. The transfer is complete on the
//                falling edge of the sideband busy flag, detected against a
//                registered copy of busy; 'sent' pulses for that one cycle.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                send                 - owner state wants a message out
//                code/data_valid/data - message contents
//                sb_busy              - sideband busy
//                tx_msg_valid, encoded_msg, tx_data_valid, tx_data_bus
//                                     - sideband request outputs
//                sent                 - busy falling edge seen while sending
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_msg_sender #(
   parameter int MSG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 send,
   input  logic [MSG_WIDTH-1:0] code,
   input  logic                 data_valid,
   input  logic [15:0]          data,
   input  logic                 sb_busy,
   output logic                 tx_msg_valid,
   output logic [MSG_WIDTH-1:0] encoded_msg,
   output logic                 tx_data_valid,
   output logic [15:0]          tx_data_bus,
   output logic                 sent
);

   logic busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= sb_busy;
      end
   end

   // Outputs are gated by 'send' so they fall to zero the moment the owner
   // leaves its send state (including on an asynchronous reset).
   assign tx_msg_valid  = send;
   assign encoded_msg   = send ? code : '0;
   assign tx_data_valid = send & data_valid;
   assign tx_data_bus   = (send && data_valid) ? data : 16'h0000;
   assign sent          = send & busy_q & ~sb_busy;

endmodule
`default_nettype wire

// File: rtl/rx_d2c_sweep_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rx_d2c_sweep_test_ctrl
//  Description : Runs a sweep of up to MAX_POINTS data-to-clock point tests.
//                Per point: START_REQ/START_RESP sideband exchange, one
//                cycle of LFSR clear, LFSR run until the comparator burst
//                completes (accumulating per-lane pass bits into a mask),
//                then END_REQ/END_RESP. Any wait lasting TIMEOUT_CYCLES
//                ends the sweep in ERROR. Dropping the enable aborts to IDLE.
//  Ports       : i_clk/i_rst_n            - clock, async active-low reset
//                i_rx_d2c_pt_en           - run (1) / abort (0)
//                i_datavref_or_valvref    - drives comparison_valid_en
//                i_num_points             - points requested (sampled on start)
//                i_pattern_finished, i_comparison_results - comparator side
//                i_SB_Busy, i_rx_msg_valid, i_decoded_SB_msg - sideband in
//                o_encoded_SB_msg, o_tx_msg_valid, o_tx_data_valid,
//                o_tx_data_bus            - sideband out
//                o_mainband_pattern_comparator_cw, o_comparison_valid_en
//                o_lane_pass_mask, o_point_idx, o_rx_d2c_pt_done, o_error
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_d2c_sweep_test_ctrl
   import rx_d2c_pt_pkg::*;
#(
   parameter int NUM_LANES      = 16,
   parameter int SB_MSG_WIDTH   = 4,
   parameter int MAX_POINTS     = 8,
   parameter int TIMEOUT_CYCLES = 8000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_rx_d2c_pt_en,
   input  logic                    i_datavref_or_valvref,
   input  logic [3:0]              i_num_points,
   input  logic                    i_pattern_finished,
   input  logic [NUM_LANES-1:0]    i_comparison_results,
   input  logic                    i_SB_Busy,
   input  logic                    i_rx_msg_valid,
   input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
   output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
   output logic                    o_tx_msg_valid,
   output logic                    o_tx_data_valid,
   output logic [15:0]             o_tx_data_bus,
   output logic [1:0]              o_mainband_pattern_comparator_cw,
   output logic                    o_comparison_valid_en,
   output logic [NUM_LANES-1:0]    o_lane_pass_mask,
   output logic [3:0]              o_point_idx,
   output logic                    o_rx_d2c_pt_done,
   output logic                    o_error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t                   state, state_nx;
   logic [TW-1:0]            timer, timer_nx;
   logic [NUM_LANES-1:0]     mask;
   logic [3:0]               point_idx;
   logic [4:0]               num_pts;
   logic [4:0]               req_pts;
   logic                     wait_state;
   logic                     timeout_hit;
   logic                     send;
   logic                     sent;
   logic [SB_MSG_WIDTH-1:0]  send_code;
   logic                     send_dv;
   logic [15:0]              send_data;

   // Requested point count: 0 means one point, anything above MAX_POINTS is clamped
   always_comb begin
      if (i_num_points == 4'd0) begin
         req_pts = 5'd1;
      end else if (5'(i_num_points) > 5'(MAX_POINTS)) begin
         req_pts = 5'(MAX_POINTS);
      end else begin
         req_pts = {1'b0, i_num_points};
      end
   end

   assign wait_state  = (state == ST_WAIT_START_RESP) || (state == ST_RUN) ||
                        (state == ST_WAIT_END_RESP);
   assign timeout_hit = wait_state && (timer == TW'(TIMEOUT_CYCLES - 1));

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:            state_nx = ST_SEND_START;
         ST_SEND_START:      if (sent) state_nx = ST_WAIT_START_RESP;
         ST_WAIT_START_RESP: begin
            if (i_rx_msg_valid && (i_decoded_SB_msg == SB_MSG_WIDTH'(START_RESP))) begin
               state_nx = ST_CLR_LFSR;
            end else if (timeout_hit) begin
               state_nx = ST_ERROR;
            end
         end
         ST_CLR_LFSR:        state_nx = ST_RUN;
         ST_RUN: begin
            // A finishing burst takes priority over a simultaneous timeout
            if (i_pattern_finished) begin
               state_nx = ST_SEND_END;
            end else if (timeout_hit) begin
               state_nx = ST_ERROR;
            end
         end
         ST_SEND_END:        if (sent) state_nx = ST_WAIT_END_RESP;
         ST_WAIT_END_RESP: begin
            if (i_rx_msg_valid && (i_decoded_SB_msg == SB_MSG_WIDTH'(END_RESP))) begin
               state_nx = ST_NEXT;
            end else if (timeout_hit) begin
               state_nx = ST_ERROR;
            end
         end
         ST_NEXT: begin
            if (({1'b0, point_idx} + 5'd1) < num_pts) begin
               state_nx = ST_SEND_START;
            end else begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE:            state_nx = ST_DONE;
         ST_ERROR:           state_nx = ST_ERROR;
         default:            state_nx = ST_IDLE;
      endcase
      // Enable low aborts from anywhere and also holds IDLE
      if (!i_rx_d2c_pt_en) begin
         state_nx = ST_IDLE;
      end
   end

   // Timer restarts on every state change and only runs in wait states
   always_comb begin
      if ((state_nx != state) || !wait_state) begin
         timer_nx = '0;
      end else begin
         timer_nx = timer + TW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         timer     <= '0;
         mask      <= '1;
         point_idx <= 4'd0;
         num_pts   <= 5'd0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
         if ((state == ST_IDLE) && i_rx_d2c_pt_en) begin
            num_pts   <= req_pts;
            mask      <= '1;
            point_idx <= 4'd0;
         end
         if ((state == ST_RUN) && i_rx_d2c_pt_en && i_pattern_finished) begin
            mask <= mask & i_comparison_results;
         end
         if ((state == ST_NEXT) && (state_nx == ST_SEND_START)) begin
            point_idx <= point_idx + 4'd1;
         end
      end
   end

   // Sideband request contents per send state
   always_comb begin
      send      = 1'b0;
      send_code = '0;
      send_dv   = 1'b0;
      if (state == ST_SEND_START) begin
         send      = 1'b1;
         send_code = SB_MSG_WIDTH'(START_REQ);
         send_dv   = 1'b1;
      end else if (state == ST_SEND_END) begin
         send      = 1'b1;
         send_code = SB_MSG_WIDTH'(END_REQ);
      end
   end

   // Data word: point index, rotating clock phase; LFSR pattern, 1k burst
   // and per-lane comparison are all encoded as zero.
   assign send_data = {7'b0, point_idx, 1'b0, 1'b0, clk_phase(point_idx), 1'b0};

   sb_msg_sender #(
      .MSG_WIDTH (SB_MSG_WIDTH)
   ) u_sender (
      .clk           (i_clk),
      .rst_n         (i_rst_n),
      .send          (send),
      .code          (send_code),
      .data_valid    (send_dv),
      .data          (send_data),
      .sb_busy       (i_SB_Busy),
      .tx_msg_valid  (o_tx_msg_valid),
      .encoded_msg   (o_encoded_SB_msg),
      .tx_data_valid (o_tx_data_valid),
      .tx_data_bus   (o_tx_data_bus),
      .sent          (sent)
   );

   assign o_mainband_pattern_comparator_cw = (state == ST_CLR_LFSR) ? CW_CLEAR_LFSR :
                                             (state == ST_RUN)      ? CW_LFSR : CW_IDLE;
   assign o_comparison_valid_en = ((state == ST_CLR_LFSR) || (state == ST_RUN)) &
                                  i_datavref_or_valvref;
   assign o_lane_pass_mask = mask;
   assign o_point_idx      = point_idx;
   assign o_rx_d2c_pt_done = (state == ST_DONE) || (state == ST_ERROR);
   assign o_error          = (state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_rx_d2c_sweep_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_d2c_sweep_test_ctrl
//  Description : Directed bench for rx_d2c_sweep_test_ctrl. A sideband/
//                comparator responder drives each sweep while a per-cycle
//                monitor compares outputs with a transaction-level model
//                (expected mask, expected point index, message counts).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_d2c_sweep_test_ctrl;

   localparam int T = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        dv = 1'b0;
   logic [3:0]  np = 4'd0;
   logic        pf = 1'b0;
   logic [15:0] res = 16'h0000;
   logic        busy = 1'b0;
   logic        rxv = 1'b0;
   logic [3:0]  rxmsg = 4'd0;

   logic [3:0]  code;
   logic        txv, txdv, cmpen, done, err;
   logic [15:0] bus, mask;
   logic [1:0]  cw;
   logic [3:0]  idx;

   int          n_checks = 0;
   int          n_pass = 0;
   bit          model_on = 1'b0;
   logic [15:0] exp_mask = 16'hFFFF;
   int          exp_idx = 0;
   int          exp_count = 1;
   int          n_start = 0;
   int          n_end = 0;
   logic        prev_txv = 1'b0;
   logic        en_at_edge = 1'b0;
   logic [1:0]  phase_log [3];
   logic [3:0]  idx_log [3];
   logic [15:0] s1_res [3];

   rx_d2c_sweep_test_ctrl #(
      .NUM_LANES (16), .SB_MSG_WIDTH (4), .MAX_POINTS (8), .TIMEOUT_CYCLES (T)
   ) dut (
      .i_clk                            (clk),
      .i_rst_n                          (rst_n),
      .i_rx_d2c_pt_en                   (en),
      .i_datavref_or_valvref            (dv),
      .i_num_points                     (np),
      .i_pattern_finished               (pf),
      .i_comparison_results             (res),
      .i_SB_Busy                        (busy),
      .i_rx_msg_valid                   (rxv),
      .i_decoded_SB_msg                 (rxmsg),
      .o_encoded_SB_msg                 (code),
      .o_tx_msg_valid                   (txv),
      .o_tx_data_valid                  (txdv),
      .o_tx_data_bus                    (bus),
      .o_mainband_pattern_comparator_cw (cw),
      .o_comparison_valid_en            (cmpen),
      .o_lane_pass_mask                 (mask),
      .o_point_idx                      (idx),
      .o_rx_d2c_pt_done                 (done),
      .o_error                          (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) en_at_edge <= en;

   // Per-cycle monitor against the model
   always @(negedge clk) begin
      if (rst_n) begin
         if (txv && !prev_txv) begin
            if (code == 4'd1) n_start++;
            else if (code == 4'd3) n_end++;
         end
         prev_txv = txv;
         if (model_on) begin
            check("cw_legal", 32'(cw != 2'b11), 1);
            check("cmp_en_vs_cw", 32'(cmpen), (cw != 2'b00) ? 32'(dv) : 0);
            check("mask_model", 32'(mask), 32'(exp_mask));
            check("error_implies_done", 32'(!err || done), 1);
            if (txv) begin
               check("msg_code_legal", 32'(code == 4'd1 || code == 4'd3), 1);
               check("data_valid_vs_code", 32'(txdv), 32'(code == 4'd1));
               check("point_idx_model", 32'(idx), exp_idx);
               if (txdv) begin
                  check("data_bus_model", 32'(bus), ((exp_idx % 3) * 2) + (exp_idx * 32));
               end
            end else begin
               check("data_valid_idle", 32'(txdv), 0);
            end
            if (!en_at_edge) begin
               check("ctrl_low_after_disable", 32'({txv, txdv, cw, cmpen, done, err}), 0);
            end
         end
      end else begin
         prev_txv = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_sweep(input logic vref, input logic [3:0] pts);
      dv = vref;
      np = pts;
      en = 1'b1;
      n_start = 0;
      n_end = 0;
      tick();
      exp_mask = 16'hFFFF;
      exp_idx = 0;
      exp_count = (pts == 0) ? 1 : ((pts > 8) ? 8 : int'(pts));
   endtask

   task automatic wait_msg(input logic [3:0] c, input string name);
      for (int k = 0; k < 50; k++) begin
         if (txv && code == c) break;
         tick();
      end
      check(name, 32'(txv && code == c), 1);
   endtask

   task automatic sb_handshake();
      busy = 1'b1;
      tick();
      tick();
      busy = 1'b0;
      tick();
      check("handshake_release", 32'(txv), 0);
   endtask

   task automatic send_resp(input logic [3:0] c);
      rxv = 1'b1;
      rxmsg = c;
      tick();
      rxv = 1'b0;
      rxmsg = 4'd0;
   endtask

   task automatic start_point();
      wait_msg(4'd1, "start_req_seen");
      sb_handshake();
   endtask

   task automatic run_pattern(input logic [15:0] r, input int delay);
      send_resp(4'd2);
      check("cw_clear", 32'(cw), 1);
      tick();
      check("cw_lfsr", 32'(cw), 2);
      repeat (delay) tick();
      pf = 1'b1;
      res = r;
      tick();
      pf = 1'b0;
      exp_mask = exp_mask & r;
      check("cw_after_finish", 32'(cw), 0);
      check("no_error_after_finish", 32'(err), 0);
   endtask

   task automatic end_point();
      wait_msg(4'd3, "end_req_seen");
      sb_handshake();
      send_resp(4'd4);
      if (exp_idx + 1 < exp_count) exp_idx++;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 20; k++) begin
         if (done) break;
         tick();
      end
      check("done_reached", 32'(done), 1);
   endtask

   task automatic disable_run();
      en = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      int k;
      s1_res[0] = 16'hFFFF;
      s1_res[1] = 16'hFF0F;
      s1_res[2] = 16'hF0FF;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_mask", 32'(mask), 32'hFFFF);
      check("rst_ctrl", 32'({txv, txdv, cw, cmpen, done, err}), 0);
      check("rst_idx", 32'(idx), 0);
      check("rst_code_bus", 32'({code, bus}), 0);
      rst_n = 1'b1;
      tick();

      // Three-point sweep with mixed lane results
      model_on = 1'b1;
      start_sweep(1'b1, 4'd3);
      for (int p = 0; p < 3; p++) begin
         wait_msg(4'd1, "s1_start_req");
         phase_log[p] = bus[2:1];
         idx_log[p] = idx;
         sb_handshake();
         run_pattern(s1_res[p], 3);
         end_point();
      end
      wait_done();
      check("s1_mask", 32'(mask), 32'hF00F);
      check("s1_error", 32'(err), 0);
      check("s1_phase0", 32'(phase_log[0]), 0);
      check("s1_phase1", 32'(phase_log[1]), 1);
      check("s1_phase2", 32'(phase_log[2]), 2);
      check("s1_idx0", 32'(idx_log[0]), 0);
      check("s1_idx1", 32'(idx_log[1]), 1);
      check("s1_idx2", 32'(idx_log[2]), 2);
      check("s1_n_start", n_start, 3);
      check("s1_n_end", n_end, 3);
      disable_run();
      check("s1_done_cleared", 32'(done), 0);
      check("s1_mask_kept", 32'(mask), 32'hF00F);

      // Zero points -> one point; burst finish coincides with the timeout
      start_sweep(1'b0, 4'd0);
      start_point();
      run_pattern(16'h1234, T - 1);
      end_point();
      wait_done();
      repeat (5) tick();
      check("s2_n_start", n_start, 1);
      check("s2_n_end", n_end, 1);
      check("s2_mask", 32'(mask), 32'h1234);
      check("s2_done_no_err", 32'({done, err}), 32'b10);
      disable_run();

      // START_RESP withheld -> timeout after T cycles in the wait state
      start_sweep(1'b0, 4'd1);
      start_point();
      k = 0;
      while (k < 100) begin
         tick();
         k++;
         if (err) break;
      end
      check("s3_timeout_cycles", k, T);
      check("s3_done_err", 32'({done, err}), 32'b11);
      disable_run();
      check("s3_err_cleared", 32'({done, err}), 0);

      // Wrong codes ignored in WAIT_START_RESP, then enable drop in RUN
      start_sweep(1'b1, 4'd2);
      start_point();
      send_resp(4'd4);
      check("s4_end_resp_ignored", 32'(cw), 0);
      send_resp(4'd7);
      check("s4_other_ignored", 32'({cw, txv, done, err}), 0);
      run_pattern(16'hA5A5, 3);
      end_point();
      start_point();
      send_resp(4'd2);
      tick();
      check("s5_in_run", 32'({cw, cmpen}), 32'b101);
      disable_run();
      check("s5_abort_ctrl", 32'({cw, cmpen, txv}), 0);
      check("s5_mask_kept", 32'(mask), 32'hA5A5);

      // Async reset while SEND_START of the second point
      start_sweep(1'b0, 4'd2);
      start_point();
      run_pattern(16'h0F0F, 3);
      end_point();
      wait_msg(4'd1, "s6_start_req");
      check("s6_pre_idx", 32'(idx), 1);
      model_on = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_rst_ctrl", 32'({txv, txdv, cw, cmpen, done, err}), 0);
      check("s6_rst_code_bus", 32'({code, bus}), 0);
      check("s6_rst_mask", 32'(mask), 32'hFFFF);
      check("s6_rst_idx", 32'(idx), 0);
      en = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
